// File: rtl/scan_sel_gen.sv
// scan_sel_gen - scan controller for a 4:1 display multiplexer.
//
// Steps the mux selects {clky,clkz} through w, x, y, z, one slot of DIV
// clock cycles each. The matching active-low digit enable is held off for the
// first BLANK cycles of every slot, so no digit is driven while the select
// settles. A one-cycle tick marks the first cycle of each new slot.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; 0 freezes the scan and blanks the display
//   digit_mask in   [3:0] digits taking part in the scan (SCAN_MASK_EN only)
//   clky       out  mux select MSB (phase[1])
//   clkz       out  mux select LSB (phase[0])
//   an         out  [3:0] digit enables, active low, bit i = digit i
//   tick       out  one-cycle pulse at each slot boundary
//
// Optional feature macro: SCAN_MASK_EN (adds digit_mask and skips digits
// whose mask bit is clear).
//
// Enable decode states:
//   state | meaning
//   BLANK | en_q low or cnt < BLANK; all enables off
//   ON    | en_q high and cnt >= BLANK; only digit 'phase' enabled
//
// Every output is decoded from flops; there is no input-to-output path.

module scan_sel_gen #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef SCAN_MASK_EN
  input  logic [3:0] digit_mask,
`endif
  output logic       clky,
  output logic       clkz,
  output logic [3:0] an,
  output logic       tick
);

  localparam logic [CW-1:0] LAST_C  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_phase;
  logic          r_en_q;
  logic          r_tick;
`ifdef SCAN_MASK_EN
  logic [3:0]    r_mask;
  logic          w_found;
`endif

  logic [1:0]    w_next_phase;
  logic          w_in_blank;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST_C);

  // With BLANK=0 the blanking window does not exist; a generate keeps the
  // always-false unsigned compare out of the netlist.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = (r_cnt < BLANK_C);
    end
  endgenerate

`ifdef SCAN_MASK_EN
  // Search phase+1 .. phase+4 for the first digit in the mask; the fourth
  // candidate is the current digit itself. An empty mask holds the phase.
  always_comb begin
    w_next_phase = r_phase;
    w_found      = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && digit_mask[r_phase + 2'(i)]) begin
        w_next_phase = r_phase + 2'(i);
        w_found      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_next_phase = r_phase + 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
      r_en_q  <= 1'b0;
      r_tick  <= 1'b0;
`ifdef SCAN_MASK_EN
      r_mask  <= 4'hF;
`endif
    end else begin
      r_en_q <= en;
      r_tick <= 1'b0;
      // en low wins over a pending wrap: cnt parks at DIV-1 and the wrap
      // happens on the next enabled cycle.
      if (en) begin
        if (w_wrap) begin
          r_cnt   <= '0;
          r_phase <= w_next_phase;
          r_tick  <= 1'b1;
`ifdef SCAN_MASK_EN
          r_mask  <= digit_mask;
`endif
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign clky = r_phase[1];
  assign clkz = r_phase[0];
  assign tick = r_tick;

  always_comb begin
    an = 4'b1111;
`ifdef SCAN_MASK_EN
    // Mask is sampled at the wrap, so a digit dropped from the mask (or an
    // empty mask) blanks from the slot boundary on, never mid-slot.
    if (r_en_q && !w_in_blank && r_mask[r_phase]) begin
      an = ~(4'b0001 << r_phase);
    end
`else
    if (r_en_q && !w_in_blank) begin
      an = ~(4'b0001 << r_phase);
    end
`endif
  end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Sequential scan controller sitting directly upstream of the 4:1 display multiplexer.
- Generates the two select lines clky/clkz that steer the multiplexer through inputs w, x, y, z in turn.
- Generates matching active-low digit enables with a programmable blanking gap at each slot start, so the multiplexer output never drives a digit while its select is changing.
- Also produces a one-cycle slot tick for downstream housekeeping.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range 2..2^CW.
- BLANK, 4, cycles at the start of each slot with all enables off; 0 <= BLANK < DIV.
- CW, 16, prescaler counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 freezes the scan and blanks the display.
- clky  out  1  mux select MSB (phase[1]).
- clkz  out  1  mux select LSB (phase[0]).
- an  out  4  digit enables, active low; bit i selects digit i.
- tick  out  1  one-cycle pulse at each slot boundary.

Behaviour:
- Single clock and asynchronous active-low reset, as decided.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- Reset (rst_n=0): applies immediately and asynchronously.
  - Values: cnt=0, phase=0, en_q=0, clky=0, clkz=0, an=4'b1111, tick=0.
  - Reset asserted mid-slot aborts the slot. After release, scanning restarts from phase 0, cnt 0.
- en_q: en registered every cycle.
- Prescaler, when en=1:
  - cnt increments by 1 each cycle.
  - At cnt==DIV-1, cnt wraps to 0 and phase advances to (phase+1) mod 4, so 3 wraps to 0.
  - tick is registered high for exactly the cycle in which the new phase first appears.
- When en=0: cnt and phase hold, tick=0. From the next edge on, en_q=0 and an=4'b1111.
- Select outputs: {clky,clkz} = phase, giving 00→w, 01→x, 10→y, 11→z. They change only on a slot boundary.
- Enable decode:
  - BLANK state (cnt < BLANK, or en_q=0): an=4'b1111.
  - ON state (en_q=1 and cnt >= BLANK): an = ~(4'b0001 << phase).
  - Exactly one enable bit is low in ON.
  - With BLANK=0 the BLANK state occurs only while en_q=0.
- Simultaneous events:
  - en falling on the wrap cycle: the wrap and tick are suppressed (en=0 wins); cnt holds at DIV-1.
  - After en returns, the next enabled cycle performs the wrap.
- Width: cnt is CW bits; DIV-1 must be representable; no other arithmetic overflow is possible.

Optional Feature:
- Macro: SCAN_MASK_EN.
- Defined:
  - Adds input digit_mask [3:0]; bit i=1 means digit i is in the scan.
  - At each wrap, phase moves to the first enabled index among phase+1, phase+2, phase+3, phase+4 (mod 4). It stays put if only the current digit is enabled.
  - If digit_mask==0: an=4'b1111 permanently, phase holds, tick still pulses at each wrap.
  - A mask change takes effect at the next wrap only.
- Undefined: the port is absent and all four digits are scanned in order 0,1,2,3.

Test Plan:
- Async reset: DIV=8, BLANK=2, pulse rst_n low at cnt=5, phase=2, between clock edges → an=1111, clky=clkz=0, tick=0 with no clock edge; after release, phase 0 resumes.
- Full cycle: DIV=8, BLANK=2, en=1 held → each slot is 8 cycles; {clky,clkz} steps 00,01,10,11,00.
  - an per slot = 1111 for 2 cycles, then 1110 / 1101 / 1011 / 0111 for 6 cycles.
- Tick: same setup for 64 cycles → exactly 8 tick pulses, each 1 cycle wide, spaced 8 cycles apart, coincident with the select change.
- Enable pause: drop en at cnt=5, phase 1 for 10 cycles → cnt stays 5, an=1111 from the next edge, no tick.
  - On re-enable, cnt continues 6,7; wrap to phase 2; an=1101 resumes once en_q=1.
- No blanking: DIV=4, BLANK=0, en=1 → an never 1111 after the first enabled edge; select changes coincide with the enable change.
- Mask (SCAN_MASK_EN): digit_mask=0101 → phase sequence 0,2,0,2 and an alternates 1110/1011.
  - Set mask=0000 → an=1111 from the next wrap, phase frozen, tick continues.
